// File: rtl/fifo_cascade_rr_arbiter.sv
// Round-robin mover: pops one word at a time from N standard-mode source FIFOs into one sink FIFO.
// Latency: rd_en_0 one cycle after request, wr_en_1 two cycles later; 4 cycles per word minimum; stalls in WAITF while full_1.
module fifo_cascade_rr_arbiter #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int IDW = 2
) (
    input  logic             int_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     empty_0,
    input  logic [N*W-1:0]   dout_0,
    input  logic             full_1,
    output logic [N-1:0]     rd_en_0,
    output logic [W-1:0]     din_1,
    output logic             wr_en_1,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic [15:0]      xfer_cnt
);

    typedef enum logic [2:0] {IDLE, RD, LAT, WAITF, WR} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant, last_grant_nxt;
    logic [N-1:0]   rd_en_nxt;
    logic [W-1:0]   din_nxt;
    logic           wr_en_nxt;
    logic [IDW-1:0] grant_nxt;
    logic [15:0]    cnt_nxt;
    logic           pick_vld;
    logic [IDW-1:0] pick_id;

    // Rotating priority search starting just after the last served source.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(last_grant) + 1 + k) % N;
            if (!pick_vld && !empty_0[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        rd_en_nxt      = '0;
        wr_en_nxt      = 1'b0;
        din_nxt        = din_1;
        grant_nxt      = grant_id;
        cnt_nxt        = xfer_cnt;
        case (state)
            IDLE: begin
                if (en && pick_vld && !full_1) begin
                    rd_en_nxt          = '0;
                    rd_en_nxt[pick_id] = 1'b1;
                    grant_nxt          = pick_id;
                    state_nxt          = RD;
                end
            end
            RD: state_nxt = LAT;
            LAT: begin
                din_nxt = dout_0[grant_id*W +: W];
                if (!full_1) begin
                    wr_en_nxt = 1'b1;
                    state_nxt = WR;
                end else begin
                    state_nxt = WAITF;
                end
            end
            WAITF: begin
                if (!full_1) begin
                    wr_en_nxt = 1'b1;
                    state_nxt = WR;
                end
            end
            WR: begin
                cnt_nxt        = xfer_cnt + 16'd1;
                last_grant_nxt = grant_id;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset wins over a pending write, so a popped word is simply dropped.
    always_ff @(posedge int_clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(N - 1);
            rd_en_0    <= '0;
            wr_en_1    <= 1'b0;
            din_1      <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            rd_en_0    <= rd_en_nxt;
            wr_en_1    <= wr_en_nxt;
            din_1      <= din_nxt;
            grant_id   <= grant_nxt;
            busy       <= (state_nxt != IDLE);
            xfer_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_cascade_rr_arbiter.sv
// Bench for fifo_cascade_rr_arbiter: source FIFO models, scoreboard of expected sink writes, directed scenarios.
module tb_fifo_cascade_rr_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int IDW = 2;

    logic           int_clk;
    logic           rst;
    logic           en;
    logic [N-1:0]   empty_0;
    logic [N*W-1:0] dout_0;
    logic           full_1;
    logic [N-1:0]   rd_en_0;
    logic [W-1:0]   din_1;
    logic           wr_en_1;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic [15:0]    xfer_cnt;

    fifo_cascade_rr_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .int_clk(int_clk), .rst(rst), .en(en), .empty_0(empty_0), .dout_0(dout_0),
        .full_1(full_1), .rd_en_0(rd_en_0), .din_1(din_1), .wr_en_1(wr_en_1),
        .grant_id(grant_id), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    initial begin
        int_clk = 1'b0;
        forever #5 int_clk = ~int_clk;
    end

    // Standard-mode source FIFO models: data appears the cycle after rd_en.
    logic [W-1:0] mem [N][8];
    int           wp [N];
    int           rp [N];
    logic [W-1:0] dout_r [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            dout_r[i] = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            empty_0[i] = (wp[i] == rp[i]);
            dout_0[i*W +: W] = dout_r[i];
        end
    end

    always @(posedge int_clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en_0[i] && wp[i] != rp[i]) begin
                dout_r[i] <= mem[i][rp[i] % 8];
                rp[i] <= rp[i] + 1;
            end
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   dat;
        logic [15:0]    cnt;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load(input int s, input logic [W-1:0] d);
        mem[s][wp[s] % 8] = d;
        wp[s] = wp[s] + 1;
    endtask

    task automatic expect_wr(input int s, input logic [W-1:0] d, input logic [15:0] c);
        exp_t e;
        e.id = IDW'(s);
        e.dat = d;
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic wait_rd();
        int n = 0;
        while (rd_en_0 == '0 && n < 50) begin
            @(negedge int_clk);
            n++;
        end
        if (rd_en_0 == '0) begin
            checks++;
            errors++;
            $display("FAIL wait_rd timeout actual=0 required=nonzero");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy || empty_0 != '1) && n < 400) begin
            @(negedge int_clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL drain timeout actual=%0d pending required=0", sb.size());
        end
        repeat (2) @(negedge int_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge int_clk);
        rst = 1'b0;
    endtask

    // Monitor: every sink write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge int_clk);
            if (!rst) begin
                if (rd_en_0 != '0) begin
                    chk("rd_onehot", 32'($onehot(rd_en_0)), 32'd1);
                    chk("rd_wr_overlap", 32'(wr_en_1), 32'd0);
                end
                if (wr_en_1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual din=%0h id=%0d required=none", din_1, grant_id);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_data", 32'(din_1), 32'(e.dat));
                        chk("wr_id", 32'(grant_id), 32'(e.id));
                        @(negedge int_clk);
                        if (!rst) chk("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b1;
        en = 1'b1;
        full_1 = 1'b0;
        repeat (3) @(negedge int_clk);
        chk("rst_rd_en", 32'(rd_en_0), 32'd0);
        chk("rst_wr_en", 32'(wr_en_1), 32'd0);
        chk("rst_din", 32'(din_1), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b0;
        @(negedge int_clk);

        // Single source 2
        load(2, 16'hA5A5);
        expect_wr(2, 16'hA5A5, 16'd1);
        @(negedge int_clk);
        chk("single_rd_en", 32'(rd_en_0), 32'b0100);
        chk("single_grant", 32'(grant_id), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        @(negedge int_clk);
        chk("single_rd_drop", 32'(rd_en_0), 32'd0);
        chk("single_lat_wr", 32'(wr_en_1), 32'd0);
        @(negedge int_clk);
        chk("single_wr_en", 32'(wr_en_1), 32'd1);
        @(negedge int_clk);
        chk("single_idle", 32'(busy), 32'd0);
        drain();

        // Round-robin from a fresh reset: grants 0,1,2,3 repeating
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < N; s++) begin
                load(s, 16'((s << 12) | k));
                expect_wr(s, 16'((s << 12) | k), 16'(4 * k + s + 1));
            end
        drain();
        chk("rr_cnt", 32'(xfer_cnt), 32'd12);

        // Sink stall during LAT
        load(1, 16'hBEEF);
        expect_wr(1, 16'hBEEF, 16'd13);
        @(negedge int_clk);
        chk("stall_rd_en", 32'(rd_en_0), 32'b0010);
        full_1 = 1'b1;
        @(negedge int_clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge int_clk);
            chk("stall_no_wr", 32'(wr_en_1), 32'd0);
            chk("stall_din_hold", 32'(din_1), 32'hBEEF);
            chk("stall_no_rd", 32'(rd_en_0), 32'd0);
        end
        full_1 = 1'b0;
        @(negedge int_clk);
        chk("stall_release_wr", 32'(wr_en_1), 32'd1);
        drain();

        // Enable gating
        en = 1'b0;
        for (int s = 0; s < N; s++) load(s, 16'(16'hC000 + s));
        expect_wr(2, 16'hC002, 16'd14);
        expect_wr(3, 16'hC003, 16'd15);
        expect_wr(0, 16'hC000, 16'd16);
        expect_wr(1, 16'hC001, 16'd17);
        seen = 1'b0;
        repeat (20) begin
            @(negedge int_clk);
            if (rd_en_0 != '0) seen = 1'b1;
        end
        chk("en_gate_idle", 32'(seen), 32'd0);
        en = 1'b1;
        @(negedge int_clk);
        wait_rd();
        chk("en_grant", 32'(rd_en_0), 32'b0100);
        en = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge int_clk);
            if (rd_en_0 != '0) seen = 1'b1;
        end
        chk("en_gate_after_rd", 32'(seen), 32'd0);
        chk("en_inflight_done", 32'(xfer_cnt), 32'd14);
        en = 1'b1;
        drain();

        // Reset during LAT drops the popped word
        load(3, 16'hDEAD);
        @(negedge int_clk);
        wait_rd();
        chk("rstmid_rd_en", 32'(rd_en_0), 32'b1000);
        @(negedge int_clk);
        rst = 1'b1;
        @(negedge int_clk);
        chk("rstmid_wr_en", 32'(wr_en_1), 32'd0);
        chk("rstmid_din", 32'(din_1), 32'd0);
        chk("rstmid_grant", 32'(grant_id), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge int_clk);
        load(1, 16'h0111);
        load(0, 16'h0101);
        expect_wr(0, 16'h0101, 16'd1);
        expect_wr(1, 16'h0111, 16'd2);
        @(negedge int_clk);
        chk("rstmid_first_grant", 32'(rd_en_0), 32'b0001);
        drain();

        // Counter wrap
        force dut.xfer_cnt = 16'hFFFF;
        @(negedge int_clk);
        release dut.xfer_cnt;
        @(negedge int_clk);
        load(2, 16'h7777);
        expect_wr(2, 16'h7777, 16'h0000);
        drain();
        chk("wrap_cnt", 32'(xfer_cnt), 32'h0000);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_cascade_rr_arbiter.md
Name: fifo_cascade_rr_arbiter

Overview:
- Moves words from N upstream standard-mode FIFOs into one shared downstream FIFO. Standard mode means read data is valid on the cycle after rd_en.
- Sources are served round-robin, one word per grant.
- Sits between the per-channel source FIFOs (side 0) and the merged sink FIFO (side 1) on the int_clk domain.
- Replaces per-channel point-to-point transfer state machines wherever several FIFOs share one sink.

Parameters:
- N, 4, number of source FIFOs; range 2..16.
- W, 16, data width of each source and of the sink.
- IDW, 2, width of grant_id; must equal ceil(log2(N)).

Ports:
- int_clk  in  1  single clock for the whole block.
- rst  in  1  reset; synchronous to int_clk, active-high.
- en  in  1  when 1, new grants are allowed; when 0, no new grant is issued and any in-flight transfer still completes.
- empty_0  in  N  empty flags of the source FIFOs; bit i belongs to source i.
- dout_0  in  N*W  source read data; source i occupies bits [i*W +: W].
- full_1  in  1  full flag of the sink FIFO.
- rd_en_0  out  N  one-hot read strobe to the source FIFOs.
- din_1  out  W  registered write data to the sink FIFO.
- wr_en_1  out  1  registered write strobe to the sink FIFO.
- grant_id  out  IDW  index of the source currently or most recently granted.
- busy  out  1  1 in every state other than IDLE.
- xfer_cnt  out  16  count of words written to the sink; wraps modulo 2^16.

Behaviour:
- All outputs are registered.
- Reset (on a rising int_clk edge with rst=1):
  - state=IDLE; rd_en_0=0; wr_en_1=0; din_1=0; grant_id=0; busy=0; xfer_cnt=0.
  - last_grant=N-1, so the first grant goes to source 0.
- Reset applied mid-transfer aborts the transfer. A word already popped from a source is discarded, and no sink write occurs on or after the reset edge.
- States: IDLE, RD, LAT, WAITF, WR.
- IDLE:
  - req[i] = !empty_0[i].
  - If en=1, any req bit is set, and full_1=0: pick g = the first i with req[i]=1, searching from (last_grant+1) mod N upward with wrap.
  - On a pick: rd_en_0<=onehot(g), grant_id<=g, state<=RD.
  - Otherwise remain in IDLE with all strobes low.
- RD (rd_en_0 is high for exactly this one cycle): rd_en_0<=0, state<=LAT.
- LAT (the source's dout is valid in this cycle):
  - din_1<=dout_0[grant_id slice].
  - If full_1=0: wr_en_1<=1, state<=WR. Otherwise state<=WAITF.
- WAITF: hold din_1. When full_1=0: wr_en_1<=1, state<=WR.
- WR (wr_en_1 is high for exactly this one cycle, din_1 stable):
  - wr_en_1<=0, xfer_cnt<=xfer_cnt+1 (wraps 0xFFFF->0), last_grant<=grant_id, state<=IDLE.
- Latency and throughput:
  - rd_en_0 rises 1 cycle after IDLE sees the request.
  - wr_en_1 rises 2 cycles after rd_en_0 when full_1=0.
  - Minimum period is 4 cycles per word (IDLE, RD, LAT, WR).
- Fairness: with all N sources continuously non-empty, grants go 0,1,...,N-1,0,...; no source waits more than N grants.
- Simultaneous events:
  - A source going empty in the same cycle as its pick is not possible to guard against. Source FIFOs must ignore rd_en while empty, and the word is written anyway.
  - full_1 is sampled only in IDLE, LAT and WAITF.
- Invariants:
  - At most one bit of rd_en_0 is ever high.
  - rd_en_0 and wr_en_1 are never high in the same cycle.
  - en toggling has no effect outside IDLE.
  - grant_id holds its value in IDLE after a transfer.

Test Plan:
- Single source: empty_0=4'b1011 (source 2 non-empty, 1 word 0xA5A5), full_1=0 → rd_en_0=4'b0100 for 1 cycle; 2 cycles later wr_en_1=1 with din_1=0xA5A5; grant_id=2; xfer_cnt=1; busy low again 4 cycles after the request.
- Round-robin: all 4 sources hold 3 words each → grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 writes; xfer_cnt=12; data per grant matches that source's FIFO order.
- Sink stall: full_1=1 forced while in LAT for 5 cycles → block sits in WAITF; wr_en_1 stays 0; din_1 held; wr_en_1 pulses once in the cycle after full_1 drops; no extra rd_en_0.
- Enable gating: en=0 with all sources non-empty → no rd_en_0 for 20 cycles. Drop en in RD → that transfer still writes, then no new grant.
- Reset mid-transfer: assert rst during LAT → next edge gives all outputs 0 and xfer_cnt=0; no wr_en_1; next grant after reset goes to source 0.
- Counter wrap: preload by 65535 transfers (or force xfer_cnt=0xFFFF) → one more transfer gives xfer_cnt=0x0000.
